mem_access_unit: RTL and testbench

Load/store sequencer between the accumulator datapath and data memory. Accepts one load or store request from the control unit, runs a ready/ack handshake with a variable-latency data memory, and on loads drives the register file's memory write-back port (memLoad, reg_sel, write_data) for exactly one cycle. Stores take their data from the register file's res value. Stalls the core while an access is in flight and flags memories that never respond.

---
 rtl/mem_access_if.sv | 37 +++
 rtl/mem_access_unit.sv | 114 +++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Load/store request, data-memory and register-file write-back signals
// of the memory access unit, grouped as one bundle.
interface mem_access_if #(
    parameter int ADDR_W = 8
);
    logic              ld_req;
    logic              st_req;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        dst_sel;
    logic [15:0]       res_val;
    logic              ready;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              rf_memLoad;
    logic [2:0]        rf_reg_sel;
    logic [15:0]       rf_write_data;
    logic              err;

    modport slave (
        input  ld_req, st_req, addr, dst_sel, res_val,
        input  mem_ack, mem_rdata,
        output ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
        output rf_memLoad, rf_reg_sel, rf_write_data, err
    );

    modport master (
        output ld_req, st_req, addr, dst_sel, res_val,
        output mem_ack, mem_rdata,
        input  ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_memLoad, rf_reg_sel, rf_write_data, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request at a time, ready/ack handshake with
// data memory, single-cycle register-file write-back on loads, timeout flag.
module mem_access_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_access_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WB} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [2:0]        dst_q, dst_d;
    logic [2:0]        sel_q, sel_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    // State and captured-data registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dst_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dst_q   <= dst_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept (load wins over store), wait for ack or timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dst_d   = dst_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ld_req) begin
                    state_d = REQ;
                    addr_d  = bus.addr;
                    dst_d   = bus.dst_sel;
                    we_d    = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end else if (bus.st_req) begin
                    state_d = REQ;
                    addr_d  = bus.addr;
                    wdata_d = bus.res_val;
                    we_d    = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (!we_q) begin
                        sel_d   = dst_q;
                        rdata_d = bus.mem_rdata;
                        state_d = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready         = (state_q == IDLE);
    assign bus.stall         = (state_q != IDLE);
    assign bus.mem_req       = (state_q == REQ);
    assign bus.mem_we        = we_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.rf_memLoad    = (state_q == WB);
    assign bus.rf_reg_sel    = sel_q;
    assign bus.rf_write_data = rdata_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table,
// randomized transactions against a transaction-level model, corner cases.
module tb_mem_access_unit;
    localparam int AW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(AW)) m ();

    mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m.slave)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [7:0]  addr;
        logic [2:0]  dst;
        logic [15:0] res;
        int          lat;
        logic [15:0] rdata;
        logic        breq;
        logic        we;
        int          reqc;
        int          busy;
        int          wb;
        logic        err;
        logic [2:0]  sel;
        logic [15:0] wd;
        logic [15:0] mwd;
    } vec_t;

    vec_t tbl[7];

    logic [2:0]  mdl_sel;
    logic [15:0] mdl_data;
    logic [15:0] mdl_wd;

    task automatic chk(input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, id, act, exp);
        end
    endtask

    task automatic chk_reset(input int id);
        chk(id, "rst_ready", 32'(m.ready), 1);
        chk(id, "rst_stall", 32'(m.stall), 0);
        chk(id, "rst_mem_req", 32'(m.mem_req), 0);
        chk(id, "rst_mem_we", 32'(m.mem_we), 0);
        chk(id, "rst_mem_addr", 32'(m.mem_addr), 0);
        chk(id, "rst_mem_wdata", 32'(m.mem_wdata), 0);
        chk(id, "rst_memLoad", 32'(m.rf_memLoad), 0);
        chk(id, "rst_reg_sel", 32'(m.rf_reg_sel), 0);
        chk(id, "rst_wdata", 32'(m.rf_write_data), 0);
        chk(id, "rst_err", 32'(m.err), 0);
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle.
    task automatic run(input int id, input vec_t v);
        int reqc, busy, wbc, badbus, guard;
        logic [2:0]  sel;
        logic [15:0] wd;
        reqc = 0; busy = 0; wbc = 0; badbus = 0; guard = 0;
        sel = m.rf_reg_sel;
        wd  = m.rf_write_data;
        chk(id, "ready_pre", 32'(m.ready), 1);
        m.ld_req = v.ld; m.st_req = v.st;
        m.addr = v.addr; m.dst_sel = v.dst; m.res_val = v.res;
        @(negedge clk);
        m.ld_req = 1'b0; m.st_req = 1'b0;
        m.addr = 8'($urandom); m.dst_sel = 3'($urandom);
        m.res_val = 16'($urandom);
        chk(id, "err_cleared", 32'(m.err), 0);
        while (m.ready == 1'b0 && guard < 300) begin
            busy++;
            if (m.stall !== 1'b1) badbus++;
            if (m.mem_req) begin
                reqc++;
                if (m.mem_we !== v.we || m.mem_addr !== v.addr ||
                    m.mem_wdata !== v.mwd) badbus++;
                m.mem_ack = (reqc == v.lat);
                m.mem_rdata = m.mem_ack ? v.rdata : 16'($urandom);
            end else begin
                m.mem_ack = 1'b0;
            end
            if (m.rf_memLoad) begin
                wbc++;
                sel = m.rf_reg_sel;
                wd  = m.rf_write_data;
            end
            m.ld_req = v.breq & 1'($urandom);
            m.st_req = v.breq & 1'($urandom);
            @(negedge clk);
            guard++;
        end
        m.ld_req = 1'b0; m.st_req = 1'b0; m.mem_ack = 1'b0;
        chk(id, "completes", 32'(guard < 300), 1);
        chk(id, "req_cycles", 32'(reqc), 32'(v.reqc));
        chk(id, "busy_cycles", 32'(busy), 32'(v.busy));
        chk(id, "wb_strobes", 32'(wbc), 32'(v.wb));
        chk(id, "bus_stable", 32'(badbus), 0);
        chk(id, "err", 32'(m.err), 32'(v.err));
        chk(id, "wb_sel", 32'(sel), 32'(v.sel));
        chk(id, "wb_data", 32'(wd), 32'(v.wd));
        chk(id, "hold_sel", 32'(m.rf_reg_sel), 32'(v.sel));
        chk(id, "hold_data", 32'(m.rf_write_data), 32'(v.wd));
    endtask

    // Transaction-level expectations from the handshake rules.
    function automatic vec_t model(input vec_t r);
        vec_t  o;
        logic  ok;
        o    = r;
        ok   = (r.lat <= TO);
        o.we = !r.ld;
        o.reqc = ok ? r.lat : TO;
        o.wb   = (r.ld && ok) ? 1 : 0;
        o.err  = !ok;
        o.busy = o.reqc + o.wb;
        if (o.wb == 1) begin
            mdl_sel  = r.dst;
            mdl_data = r.rdata;
        end
        if (!r.ld) mdl_wd = r.res;
        o.sel = mdl_sel;
        o.wd  = mdl_data;
        o.mwd = mdl_wd;
        return o;
    endfunction

    initial begin
        vec_t r;
        tbl[0] = '{1'b1, 1'b0, 8'h12, 3'd3, 16'h0000, 1, 16'hBEEF, 1'b0,
                   1'b0, 1, 2, 1, 1'b0, 3'd3, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 8'h40, 3'd0, 16'h1234, 4, 16'h0000, 1'b0,
                   1'b1, 4, 4, 0, 1'b0, 3'd3, 16'hBEEF, 16'h1234};
        tbl[2] = '{1'b1, 1'b0, 8'h55, 3'd5, 16'h0000, 16, 16'hDEAD, 1'b0,
                   1'b0, 15, 15, 0, 1'b1, 3'd3, 16'hBEEF, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 8'h56, 3'd6, 16'h0000, 15, 16'h00FF, 1'b0,
                   1'b0, 15, 16, 1, 1'b0, 3'd6, 16'h00FF, 16'h1234};
        tbl[4] = '{1'b1, 1'b1, 8'h77, 3'd2, 16'hAAAA, 2, 16'h5A5A, 1'b1,
                   1'b0, 2, 3, 1, 1'b0, 3'd2, 16'h5A5A, 16'h1234};
        tbl[5] = '{1'b0, 1'b1, 8'h80, 3'd0, 16'hCAFE, 16, 16'h0000, 1'b0,
                   1'b1, 15, 15, 0, 1'b1, 3'd2, 16'h5A5A, 16'hCAFE};
        tbl[6] = '{1'b0, 1'b1, 8'hFF, 3'd0, 16'h0001, 1, 16'h0000, 1'b1,
                   1'b1, 1, 1, 0, 1'b0, 3'd2, 16'h5A5A, 16'h0001};

        m.ld_req = 1'b0; m.st_req = 1'b0; m.addr = '0; m.dst_sel = '0;
        m.res_val = '0; m.mem_ack = 1'b0; m.mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk_reset(0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset(1);

        for (int i = 0; i < 7; i++) begin
            run(i, tbl[i]);
        end
        mdl_sel  = tbl[6].sel;
        mdl_data = tbl[6].wd;
        mdl_wd   = tbl[6].mwd;

        for (int i = 0; i < 40; i++) begin
            r.ld    = 1'($urandom);
            r.st    = r.ld ? 1'($urandom) : 1'b1;
            r.addr  = 8'($urandom);
            r.dst   = 3'($urandom);
            r.res   = 16'($urandom);
            r.lat   = $urandom_range(1, TO + 2);
            r.rdata = 16'($urandom);
            r.breq  = 1'($urandom);
            run(100 + i, model(r));
        end

        m.mem_ack = 1'b1; m.mem_rdata = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(200 + i, "idle_ack_ready", 32'(m.ready), 1);
            chk(200 + i, "idle_ack_req", 32'(m.mem_req), 0);
            chk(200 + i, "idle_ack_wb", 32'(m.rf_memLoad), 0);
        end
        m.mem_ack = 1'b0;

        m.ld_req = 1'b1; m.addr = 8'h33; m.dst_sel = 3'd7;
        @(negedge clk);
        m.ld_req = 1'b0;
        chk(300, "mid_req_up", 32'(m.mem_req), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset(301);
        m.mem_ack = 1'b1; m.mem_rdata = 16'h7777;
        @(negedge clk);
        m.mem_ack = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(302 + i, "no_wb_after_rst", 32'(m.rf_memLoad), 0);
            chk(302 + i, "rst_sel_held", 32'(m.rf_reg_sel), 0);
        end
        r = '{1'b1, 1'b0, 8'h21, 3'd4, 16'h0000, 3, 16'h4242, 1'b0,
              1'b0, 3, 4, 1, 1'b0, 3'd4, 16'h4242, 16'h0000};
        run(310, r);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
